// File: rtl/cp0_irq_timer_pkg.sv
// Shared constants for the CP0 interrupt/timer block: register ids, exception
// codes and the kernel-control encoding driven to the pipeline controller.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    KCTRL_NONE  = 2'b00,
    KCTRL_KTEXT = 2'b01,
    KCTRL_ERET  = 2'b10
  } kctrl_e;

endpackage

// File: rtl/cp0_irq_timer_if.sv
// Pipeline <-> CP0 bundle: decoded strobes and trap context in, read data and
// kernel control out. The pipeline side uses master, the CP0 uses slave.
interface cp0_irq_timer_if
  import cp0_pkg::*;
#(
  parameter int N_HWINT = 6
) ();

  logic [31:0]        pc;
  logic               bd;
  logic [4:0]         exc_code;
  logic [31:0]        badvaddr;
  logic [N_HWINT-1:0] hwint;
  logic               mtc0_en;
  logic               mfc0_en;
  logic               eret;
  logic [4:0]         cp0_id;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  kctrl_e             kctrl;
  logic [29:0]        epc;
  logic               is_bd;
  logic               timer_irq;

  modport master (
    output pc, bd, exc_code, badvaddr, hwint, mtc0_en, mfc0_en, eret, cp0_id, wdata,
    input  rdata, kctrl, epc, is_bd, timer_irq
  );

  modport slave (
    input  pc, bd, exc_code, badvaddr, hwint, mtc0_en, mfc0_en, eret, cp0_id, wdata,
    output rdata, kctrl, epc, is_bd, timer_irq
  );

endinterface

// File: rtl/cp0_irq_sync.sv
// One hardware interrupt line: optional synchronizer chain, then either a
// registered level or a rising-edge latch cleared by software.
module cp0_irq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  input  logic clr_i,
  output logic pend_o
);

  logic sync;
  logic prev_q;
  logic pend_q, pend_d;

  if (SYNC_STAGES == 0) begin : g_raw
    assign sync = irq_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour and the chain shifts by one.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= irq_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_q[s] <= sync_q[s-1];
        end
      end
    end

    assign sync = sync_q[SYNC_STAGES-1];
  end

  // Edge mode: a new rising edge beats a same-cycle software clear.
  always_comb begin
    pend_d = sync;
    if (EDGE) begin
      pend_d = (sync & ~prev_q) | (pend_q & ~clr_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= sync;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/cp0_irq_timer.sv
// Coprocessor-0 with synchronized hardware interrupts, Count/Compare timer,
// BadVAddr capture and EPC protection against nested exceptions.
module cp0_irq_timer
  import cp0_pkg::*;
#(
  parameter int          N_HWINT     = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [5:0]  EDGE_MASK   = 6'b000000,
  parameter int          TIMER_EN    = 1,
  parameter int          TIMER_LINE  = 5,
  parameter logic [31:0] PRID        = 32'hbaad_face,
  parameter logic [31:0] EPC_RESET   = 32'h0000_3000
) (
  input logic             clk,
  input logic             reset,
  cp0_irq_timer_if.slave  bus
);

  localparam int TI_BIT = (TIMER_LINE >= 10) ? TIMER_LINE - 10 : TIMER_LINE;

  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, compare_q;
  logic        ti_q;
  logic [5:0]  ip_hw, ip;

  logic sr_wr, cause_wr, epc_wr, count_wr, compare_wr;
  logic int_take, exc_take, take;

  assign sr_wr      = bus.mtc0_en && (bus.cp0_id == CP0_SR);
  assign cause_wr   = bus.mtc0_en && (bus.cp0_id == CP0_CAUSE);
  assign epc_wr     = bus.mtc0_en && (bus.cp0_id == CP0_EPC);
  assign count_wr   = bus.mtc0_en && (bus.cp0_id == CP0_COUNT);
  assign compare_wr = bus.mtc0_en && (bus.cp0_id == CP0_COMPARE);

  for (genvar i = 0; i < 6; i++) begin : g_line
    if (i < N_HWINT) begin : g_on
      cp0_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (EDGE_MASK[i])
      ) u_sync (
        .clk_i  (clk),
        .rst_i  (reset),
        .irq_i  (bus.hwint[i]),
        .clr_i  (cause_wr && !bus.wdata[10+i]),
        .pend_o (ip_hw[i])
      );
    end else begin : g_off
      assign ip_hw[i] = 1'b0;
    end
  end

  if (TIMER_EN != 0) begin : g_timer
    logic [31:0] count_d, compare_d;
    logic        ti_d;

    // A Compare write always clears TI, even against a same-edge match.
    always_comb begin
      count_d   = count_wr ? bus.wdata : count_q + 32'd1;
      compare_d = compare_wr ? bus.wdata : compare_q;
      ti_d      = compare_wr ? 1'b0 : (ti_q | (count_d == compare_q));
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q   <= '0;
        compare_q <= '0;
        ti_q      <= 1'b0;
      end else begin
        count_q   <= count_d;
        compare_q <= compare_d;
        ti_q      <= ti_d;
      end
    end
  end else begin : g_no_timer
    assign count_q   = '0;
    assign compare_q = '0;
    assign ti_q      = 1'b0;
  end

  always_comb begin
    ip         = ip_hw;
    ip[TI_BIT] = ip_hw[TI_BIT] | ti_q;
  end

  assign int_take = (|(ip & im_q)) & ie_q & ~exl_q;
  assign exc_take = (bus.exc_code != EXC_INT);
  assign take     = int_take | exc_take;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (take) begin
      exccode_d = int_take ? EXC_INT : bus.exc_code;
      if (!exl_q) begin
        epc_d = bus.bd ? bus.pc - 32'd4 : bus.pc;
        bd_d  = bus.bd;
      end
      exl_d = 1'b1;
      if (!int_take && (bus.exc_code == EXC_ADEL || bus.exc_code == EXC_ADES)) begin
        badvaddr_d = bus.badvaddr;
      end
    end else begin
      if (bus.eret) begin
        exl_d     = 1'b0;
        exccode_d = EXC_INT;
        bd_d      = 1'b0;
      end
      if (sr_wr) begin
        im_d  = bus.wdata[15:10];
        exl_d = bus.wdata[1];
        ie_d  = bus.wdata[0];
      end
      if (epc_wr) begin
        epc_d = bus.wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '1;
      ie_q       <= 1'b1;
      exl_q      <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= EXC_INT;
      epc_q      <= EPC_RESET;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    bus.kctrl = KCTRL_NONE;
    if (!reset) begin
      if (take) begin
        bus.kctrl = KCTRL_KTEXT;
      end else if (bus.eret) begin
        bus.kctrl = KCTRL_ERET;
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (!reset && bus.mfc0_en) begin
      case (bus.cp0_id)
        CP0_BADVADDR: bus.rdata = badvaddr_q;
        CP0_COUNT:    bus.rdata = count_q;
        CP0_COMPARE:  bus.rdata = compare_q;
        CP0_SR:       bus.rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
        CP0_CAUSE:    bus.rdata = {bd_q, ti_q, 14'b0, ip, 3'b0, exccode_q, 2'b0};
        CP0_EPC:      bus.rdata = epc_q;
        CP0_PRID:     bus.rdata = PRID;
        default:      bus.rdata = '0;
      endcase
    end
  end

  assign bus.is_bd     = bus.bd & take & ~reset;
  assign bus.epc       = epc_q[31:2];
  assign bus.timer_irq = ti_q;

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Directed bench for cp0_irq_timer: the driver queues expected read data and
// per-cycle {timer_irq, is_bd, kctrl}; a negedge monitor pops and compares.
module tb_cp0_irq_timer;
  import cp0_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_irq_timer_if #(.N_HWINT(6)) bus ();

  cp0_irq_timer #(
    .N_HWINT     (6),
    .SYNC_STAGES (2),
    .EDGE_MASK   (6'b000001),
    .TIMER_EN    (1),
    .TIMER_LINE  (15),
    .PRID        (32'hbaad_face),
    .EPC_RESET   (32'h0000_3000)
  ) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t kc_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic exp_ti   = 1'b0;

  localparam logic [2:0] K0  = 3'b000;
  localparam logic [2:0] KT  = 3'b001;
  localparam logic [2:0] KTB = 3'b101;
  localparam logic [2:0] KE  = 3'b010;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.mfc0_en) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got read of id %0d expected none", bus.cp0_id);
      end else begin
        e = rd_q.pop_front();
        check(e.name, bus.rdata, e.exp);
      end
    end
    if (kc_q.size() != 0) begin
      e = kc_q.pop_front();
      check(e.name, {28'b0, bus.timer_irq, bus.is_bd, bus.kctrl}, e.exp);
    end
  end

  task automatic cyc(input string nm, input logic [2:0] exp_k);
    kc_q.push_back('{name: nm, exp: {28'b0, exp_ti, exp_k}});
    @(posedge clk);
    #1;
    bus.mtc0_en  = 1'b0;
    bus.mfc0_en  = 1'b0;
    bus.eret     = 1'b0;
    bus.exc_code = 5'd0;
  endtask

  task automatic rd(input string nm, input logic [4:0] id, input logic [31:0] exp,
                    input logic [2:0] exp_k = K0);
    bus.mfc0_en = 1'b1;
    bus.cp0_id  = id;
    rd_q.push_back('{name: nm, exp: exp});
    cyc({nm, "_k"}, exp_k);
  endtask

  task automatic wr(input string nm, input logic [4:0] id, input logic [31:0] data,
                    input logic [2:0] exp_k = K0);
    bus.mtc0_en = 1'b1;
    bus.cp0_id  = id;
    bus.wdata   = data;
    cyc(nm, exp_k);
  endtask

  initial begin
    bus.pc       = '0;
    bus.bd       = 1'b0;
    bus.exc_code = 5'd0;
    bus.badvaddr = '0;
    bus.hwint    = '0;
    bus.mtc0_en  = 1'b0;
    bus.mfc0_en  = 1'b0;
    bus.eret     = 1'b0;
    bus.cp0_id   = '0;
    bus.wdata    = '0;
    @(posedge clk);
    #1;

    // Outputs held quiet during reset even with a trap request present.
    bus.exc_code = EXC_OV;
    rd("reset_rdata", CP0_PRID, 32'h0, K0);
    rst = 1'b0;

    rd("rst_sr",       CP0_SR,       32'h0000_fc01);
    rd("rst_cause",    CP0_CAUSE,    32'h0000_0000);
    rd("rst_epc",      CP0_EPC,      32'h0000_3000);
    rd("rst_prid",     CP0_PRID,     32'hbaad_face);
    rd("rst_badvaddr", CP0_BADVADDR, 32'h0000_0000);
    rd("unmapped",     5'd10,        32'h0000_0000);

    // Level line 2: pending three cycles after the input rises.
    bus.hwint[2] = 1'b1;
    cyc("lvl_wait0", K0);
    cyc("lvl_wait1", K0);
    cyc("lvl_wait2", K0);
    bus.pc = 32'h0000_3010;
    bus.bd = 1'b1;
    cyc("lvl_take", KTB);
    bus.hwint[2] = 1'b0;
    bus.pc = '0;
    bus.bd = 1'b0;
    rd("lvl_epc",      CP0_EPC,   32'h0000_300c);
    rd("lvl_cause",    CP0_CAUSE, 32'h8000_1000);
    rd("lvl_sr_exl",   CP0_SR,    32'h0000_fc03);
    rd("lvl_dropped",  CP0_CAUSE, 32'h8000_0000);

    // Edge line 0: latch, hold, software clear, set-beats-clear.
    bus.hwint[0] = 1'b1;
    cyc("edge_pulse", K0);
    bus.hwint[0] = 1'b0;
    cyc("edge_wait", K0);
    cyc("edge_wait2", K0);
    rd("edge_set", CP0_CAUSE, 32'h8000_0400);
    cyc("edge_idle", K0);
    rd("edge_hold", CP0_CAUSE, 32'h8000_0400);
    wr("edge_clr", CP0_CAUSE, 32'h0);
    rd("edge_cleared", CP0_CAUSE, 32'h8000_0000);
    bus.hwint[0] = 1'b1;
    cyc("edge_pulse2", K0);
    bus.hwint[0] = 1'b0;
    cyc("edge_wait3", K0);
    wr("edge_clr_race", CP0_CAUSE, 32'h0);
    rd("edge_set_wins", CP0_CAUSE, 32'h8000_0400);
    wr("edge_clr2", CP0_CAUSE, 32'h0);
    rd("edge_cleared2", CP0_CAUSE, 32'h8000_0000);

    // Exception beats eret; then eret alone leaves exception level.
    bus.eret = 1'b1;
    bus.exc_code = EXC_OV;
    bus.pc = 32'h0000_5000;
    cyc("eret_vs_exc", KT);
    bus.pc = '0;
    rd("nest_ov_cause", CP0_CAUSE, 32'h8000_0030);
    rd("nest_ov_sr",    CP0_SR,    32'h0000_fc03);
    bus.eret = 1'b1;
    cyc("eret_alone", KE);
    rd("eret_sr",    CP0_SR,    32'h0000_fc01);
    rd("eret_cause", CP0_CAUSE, 32'h0000_0000);
    rd("eret_epc",   CP0_EPC,   32'h0000_300c);

    // Nested AdEL keeps EPC/BD but captures BadVAddr; take drops MTC0 EPC.
    bus.exc_code = EXC_RI;
    bus.pc = 32'h0000_4000;
    cyc("ri_take", KT);
    bus.exc_code = EXC_ADEL;
    bus.pc = 32'h0000_4180;
    bus.bd = 1'b1;
    bus.badvaddr = 32'h1234_5677;
    cyc("adel_nested", KTB);
    bus.bd = 1'b0;
    bus.pc = '0;
    rd("nest_epc",      CP0_EPC,      32'h0000_4000);
    rd("nest_cause",    CP0_CAUSE,    32'h0000_0010);
    rd("nest_badvaddr", CP0_BADVADDR, 32'h1234_5677);
    bus.exc_code = EXC_ADES;
    bus.badvaddr = 32'haaaa_0001;
    wr("epc_wr_vs_take", CP0_EPC, 32'hdead_beef, KT);
    rd("epc_wr_dropped", CP0_EPC,      32'h0000_4000);
    rd("ades_badvaddr",  CP0_BADVADDR, 32'haaaa_0001);
    rd("ades_cause",     CP0_CAUSE,    32'h0000_0014);
    bus.eret = 1'b1;
    cyc("eret2", KE);
    rd("eret2_sr", CP0_SR, 32'h0000_fc01);

    // Delay-slot trap at pc=0 wraps EPC.
    bus.exc_code = EXC_OV;
    bus.bd = 1'b1;
    cyc("wrap_take", KTB);
    bus.bd = 1'b0;
    rd("wrap_epc",   CP0_EPC,   32'hffff_fffc);
    rd("wrap_cause", CP0_CAUSE, 32'h8000_0030);
    bus.eret = 1'b1;
    cyc("eret3", KE);

    // Timer: Count reloaded to 0 reaches Compare=5 five edges later.
    wr("cmp_wr", CP0_COMPARE, 32'd5);
    wr("cnt_wr", CP0_COUNT, 32'd0);
    rd("cnt_loaded", CP0_COUNT, 32'd0);
    cyc("tmr_wait0", K0);
    rd("cnt_run", CP0_COUNT, 32'd2);
    cyc("tmr_wait1", K0);
    cyc("tmr_wait2", K0);
    exp_ti = 1'b1;
    bus.pc = 32'h0000_6000;
    rd("ti_cause", CP0_CAUSE, 32'h4000_8000, KT);
    bus.pc = '0;
    rd("ti_epc", CP0_EPC, 32'h0000_6000);
    wr("cmp_clr", CP0_COMPARE, 32'd12);
    exp_ti = 1'b0;
    cyc("tmr_wait3", K0);
    cyc("tmr_wait4", K0);
    cyc("tmr_wait5", K0);
    wr("cmp_match_race", CP0_COMPARE, 32'd100);
    rd("ti_race_cause", CP0_CAUSE, 32'h0000_0000);
    rd("cnt_after", CP0_COUNT, 32'd13);

    cyc("tail", K0);
    check("rd_q_drained", rd_q.size(), 0);
    check("kc_q_drained", kc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
